// File: rtl/decim_seq_multi_pkg.sv
// Shared types and constants for the sequential decimalizer.
// Holds BCD digit type, FSM states, field widths and powers of ten.
package decim_seq_multi_pkg;

  localparam int DECIM_MAX_DIGITS = 5;

  // Display field lengths; each selects DIGITS for one converter instance.
  localparam int OPT_FIELD_DIGITS   = 2;
  localparam int GUESS_FIELD_DIGITS = 2;
  localparam int SCORE_FIELD_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_DONE
  } decim_state_t;

  function automatic logic [16:0] powers_of_10(input int unsigned i);
    logic [16:0] r;
    case (i)
      0:       r = 17'd1;
      1:       r = 17'd10;
      2:       r = 17'd100;
      3:       r = 17'd1000;
      4:       r = 17'd10000;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decim_seq_multi_dabble_step.sv
// One double-dabble step: add 3 to digits >= 5, then shift in a bit.
// Ports: i_acc/i_bit in, o_acc shifted accumulator, o_carry bit out of top digit.
module decim_dabble_step
  import decim_seq_multi_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [DIGITS*4-1:0] i_acc,
  input  logic                i_bit,
  output logic [DIGITS*4-1:0] o_acc,
  output logic                o_carry
);

  logic [DIGITS*4-1:0] w_adj;
  bcd_digit_t          w_dig;

  // Per-digit adjust; no carry propagates between digits.
  always_comb begin
    w_adj = i_acc;
    w_dig = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_dig = i_acc[d*4 +: 4];
      if (w_dig >= 4'd5) begin
        w_adj[d*4 +: 4] = w_dig + 4'd3;
      end
    end
  end

  assign {o_carry, o_acc} = {w_adj, i_bit};

endmodule

// File: rtl/decim_seq_multi.sv
// Sequential multi-channel binary to BCD converter (double dabble).
// Ports: clk, reset, start, values_in -> busy, done, digits_out, overflow, blank.
module decim_seq_multi
  import decim_seq_multi_pkg::*;
#(
  parameter int W_IN     = 8,
  parameter int DIGITS   = OPT_FIELD_DIGITS,
  parameter int CHANNELS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CHANNELS*W_IN-1:0]     values_in,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS*DIGITS*4-1:0] digits_out,
  output logic [CHANNELS-1:0]          overflow,
  output logic [CHANNELS*DIGITS-1:0]   blank
);

  localparam int AW = DIGITS * 4;
  localparam int NW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [NW-1:0] N_TOP  = NW'(W_IN - 1);
  localparam logic [CW-1:0] CH_TOP = CW'(CHANNELS - 1);
  localparam logic [AW-1:0] NINES  = {DIGITS{4'd9}};

  decim_state_t r_state;
  decim_state_t w_next;

  logic [CHANNELS*W_IN-1:0] r_vals;
  logic [W_IN-1:0]          r_sr;
  logic [AW-1:0]            r_acc;
  logic [AW-1:0]            w_acc_nx;
  logic                     r_sticky;
  logic                     w_carry;
  logic [NW-1:0]            r_n;
  logic [CW-1:0]            r_ch;
  logic                     w_last;
  logic [CHANNELS*AW-1:0]   r_shadow;
  logic [CHANNELS*AW-1:0]   w_shadow_nx;
  logic [CHANNELS-1:0]      r_shov;
  logic [CHANNELS-1:0]      w_shov_nx;
  logic [CHANNELS*DIGITS-1:0] w_blank_nx;
  logic                     w_hi_zero;

  decim_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .i_acc   (r_acc),
    .i_bit   (r_sr[W_IN-1]),
    .o_acc   (w_acc_nx),
    .o_carry (w_carry)
  );

  assign w_last = (r_ch == CH_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_n == '0) w_next = S_STORE;
      end
      S_STORE: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shadow buffer with the current channel's result merged in.
  always_comb begin
    w_shadow_nx = r_shadow;
    w_shov_nx   = r_shov;
    w_shadow_nx[r_ch*AW +: AW] = r_sticky ? NINES : r_acc;
    w_shov_nx[r_ch]            = r_sticky;
  end

  // Leading-zero mask: scan from the top digit down to digit 1.
  always_comb begin
    w_blank_nx = '0;
    w_hi_zero  = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      w_hi_zero = 1'b1;
      for (int d = DIGITS - 1; d > 0; d--) begin
        w_hi_zero = w_hi_zero &&
          (w_shadow_nx[(c*DIGITS+d)*4 +: 4] == 4'd0);
        w_blank_nx[c*DIGITS+d] = w_hi_zero && !w_shov_nx[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vals     <= '0;
      r_sr       <= '0;
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_n        <= '0;
      r_ch       <= '0;
      r_shadow   <= '0;
      r_shov     <= '0;
      digits_out <= '0;
      overflow   <= '0;
      blank      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vals <= values_in;
            r_ch   <= '0;
          end
        end
        S_LOAD: begin
          r_acc    <= '0;
          r_sticky <= 1'b0;
          r_sr     <= r_vals[r_ch*W_IN +: W_IN];
          r_n      <= N_TOP;
        end
        S_SHIFT: begin
          r_acc <= w_acc_nx;
          r_sr  <= r_sr << 1;
          if (w_carry) r_sticky <= 1'b1;
          if (r_n != '0) r_n <= r_n - 1'b1;
        end
        S_STORE: begin
          r_shadow <= w_shadow_nx;
          r_shov   <= w_shov_nx;
          // Outputs load on entry to DONE so they are valid
          // during the done pulse, all channels at once.
          if (w_last) begin
            digits_out <= w_shadow_nx;
            overflow   <= w_shov_nx;
            blank      <= w_blank_nx;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decim_seq_multi.sv
// Randomized scoreboard bench for decim_seq_multi.
// Reference model uses decimal arithmetic; monitor pops on done.
module tb_decim_seq_multi;

  localparam int W = 8;
  localparam int D = 2;
  localparam int C = 3;
  localparam int L = C * (W + 2);

  localparam int W1 = 14;
  localparam int D1 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [C*W-1:0] values_in = '0;
  logic busy;
  logic done;
  logic [C*D*4-1:0] digits_out;
  logic [C-1:0] overflow;
  logic [C*D-1:0] blank;

  logic start1 = 1'b0;
  logic [W1-1:0] val1 = '0;
  logic busy1;
  logic done1;
  logic [D1*4-1:0] dig1;
  logic ov1;
  logic [D1-1:0] blank1;

  always #5 clk = ~clk;

  decim_seq_multi #(.W_IN(W), .DIGITS(D), .CHANNELS(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .values_in  (values_in),
    .busy       (busy),
    .done       (done),
    .digits_out (digits_out),
    .overflow   (overflow),
    .blank      (blank)
  );

  decim_seq_multi #(.W_IN(W1), .DIGITS(D1), .CHANNELS(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start1),
    .values_in  (val1),
    .busy       (busy1),
    .done       (done1),
    .digits_out (dig1),
    .overflow   (ov1),
    .blank      (blank1)
  );

  typedef struct {
    logic [C*D*4-1:0] dig;
    logic [C-1:0]     ov;
    logic [C*D-1:0]   bl;
    int               acc;
    int               fin;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int rst_cnt = 0;
  int free_edge = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Decimal reference for one channel value.
  function automatic void ref_chan(input int v, input int nd,
                                   output logic [19:0] dig,
                                   output logic ov,
                                   output logic [4:0] bl);
    int lim;
    int pw;
    lim = 1;
    for (int d = 0; d < nd; d++) lim *= 10;
    ov  = (v >= lim);
    dig = '0;
    bl  = '0;
    pw  = 1;
    for (int d = 0; d < nd; d++) begin
      dig[d*4 +: 4] = ov ? 4'd9 : 4'((v / pw) % 10);
      bl[d] = (d > 0) && !ov && (v < pw);
      pw *= 10;
    end
  endfunction

  function automatic exp_t make_exp(input logic [C*W-1:0] v,
                                    input int acc);
    exp_t e;
    logic [19:0] dg;
    logic ov;
    logic [4:0] bl;
    e.dig = '0;
    e.ov  = '0;
    e.bl  = '0;
    for (int c = 0; c < C; c++) begin
      ref_chan(int'(v[c*W +: W]), D, dg, ov, bl);
      e.dig[c*D*4 +: D*4] = dg[D*4-1:0];
      e.ov[c] = ov;
      e.bl[c*D +: D] = bl[D-1:0];
    end
    e.acc = acc;
    e.fin = acc + L;
    return e;
  endfunction

  // Model: accepts start only when idle; a conversion occupies
  // L busy cycles, one DONE cycle and one IDLE cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      free_edge = 0;
      rst_cnt++;
    end else begin
      cyc++;
      if (start && cyc >= free_edge) begin
        q.push_back(make_exp(values_in, cyc));
        free_edge = cyc + L + 2;
      end
    end
  end

  logic [C*D*4-1:0] last_dig = '0;
  logic [C-1:0]     last_ov = '0;
  logic [C*D-1:0]   last_bl = '0;
  int seen_rst = 0;
  exp_t e;

  always @(posedge clk) begin
    #1;
    if (armed) begin
      if (seen_rst != rst_cnt) begin
        seen_rst = rst_cnt;
        last_dig = '0;
        last_ov  = '0;
        last_bl  = '0;
      end
      chk("busy", busy,
          q.size() > 0 && cyc >= q[0].acc && cyc < q[0].fin);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.fin);
          chk("digits", digits_out, e.dig);
          chk("overflow", overflow, e.ov);
          chk("blank", blank, e.bl);
          last_dig = e.dig;
          last_ov  = e.ov;
          last_bl  = e.bl;
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].fin) begin
          chk("missing_done", 0, 1);
          void'(q.pop_front());
        end
        chk("hold_digits", digits_out, last_dig);
        chk("hold_ov", overflow, last_ov);
        chk("hold_blank", blank, last_bl);
      end
    end
  end

  task automatic set_vals(input int a, input int b, input int c2);
    values_in = {8'(c2), 8'(b), 8'(a)};
  endtask

  task automatic pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_digits"}, digits_out, 0);
    chk({nm, "_ov"}, overflow, 0);
    chk({nm, "_blank"}, blank, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic run1(input int v);
    int lat;
    logic [19:0] dg;
    logic ov;
    logic [4:0] bl;
    ref_chan(v, D1, dg, ov, bl);
    val1 = W1'(v);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w14_latency", lat, 16);
    chk("w14_digits", dig1, dg[15:0]);
    chk("w14_overflow", ov1, ov);
    chk("w14_blank", blank1, bl[3:0]);
    @(negedge clk);
    val1 = '0;
  endtask

  int r;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("reset");
    chk("reset_w14_digits", dig1, 0);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    set_vals(21, 20, 99);
    pulse();
    drain();

    set_vals(0, 7, 255);
    pulse();
    drain();

    // Extra starts during busy and DONE; inputs change mid-run.
    set_vals(12, 100, 9);
    pulse();
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (i == 3) values_in = C*W'($urandom);
      start = (i == 5 || i == 29 || i == 30);
    end
    start = 1'b0;
    drain();

    // Asynchronous abort mid-conversion.
    set_vals(250, 10, 55);
    pulse();
    repeat (12) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    set_vals(42, 100, 5);
    pulse();
    drain();

    // start held high: back-to-back runs on changing inputs.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      values_in = C*W'($urandom);
    end
    start = 1'b0;
    drain();

    // Random values biased toward decade edges, random extra starts.
    for (int t = 0; t < 20; t++) begin
      for (int c = 0; c < C; c++) begin
        r = $urandom_range(0, 7);
        case (r)
          0: values_in[c*W +: W] = 8'd99;
          1: values_in[c*W +: W] = 8'd100;
          2: values_in[c*W +: W] = 8'd0;
          3: values_in[c*W +: W] = 8'd10;
          default: values_in[c*W +: W] = W'($urandom);
        endcase
      end
      pulse();
      repeat ($urandom_range(0, 40)) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      drain();
    end

    run1(9999);
    run1(10000);
    run1(0);
    run1(305);
    run1(int'($urandom_range(0, 16383)));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
